// File: rtl/rf_operand_fetch.sv
// rtl/rf_operand_fetch.sv - one-entry operand fetch stage between predecode and decode.
// Optional writeback bypass registers are enabled by defining RF_WB_BYPASS_EN.
module rf_operand_fetch #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pd_valid_i,
    output logic             pd_ready_o,
    input  logic [4:0]       pd_src1_i,
    input  logic [4:0]       pd_src2_i,
    output logic [4:0]       rf_src1_o,
    output logic [4:0]       rf_src2_o,
    input  logic [XLEN-1:0]  rf_src1_q_i,
    input  logic [XLEN-1:0]  rf_src2_q_i,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_dst_i,
    input  logic [XLEN-1:0]  wb_data_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [4:0]       id_src1_o,
    output logic [4:0]       id_src2_o,
    output logic [XLEN-1:0]  id_op1_o,
    output logic [XLEN-1:0]  id_op2_o,
    input  logic             flush_i,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state;
    logic   accept;
    logic   stall;

    assign pd_ready_o = (state == EMPTY) | id_ready_i;
    assign accept     = pd_valid_i & pd_ready_o & ~flush_i;
    assign stall      = (state == FULL) & ~id_ready_i & ~flush_i;

    // Holding the address while stalled makes the RF re-read every cycle,
    // so a writeback to a held index shows up without extra state.
    assign rf_src1_o = accept ? pd_src1_i : id_src1_o;
    assign rf_src2_o = accept ? pd_src2_i : id_src2_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            id_valid_o <= 1'b0;
            id_src1_o  <= 5'd0;
            id_src2_o  <= 5'd0;
        end else if (flush_i) begin
            state      <= EMPTY;
            id_valid_o <= 1'b0;
        end else if (accept) begin
            state      <= FULL;
            id_valid_o <= 1'b1;
            id_src1_o  <= pd_src1_i;
            id_src2_o  <= pd_src2_i;
        end else if (state == FULL && id_ready_i) begin
            state      <= EMPTY;
            id_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (stall && !(&stall_cnt_o)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic            byp1_valid;
    logic            byp2_valid;
    logic [XLEN-1:0] byp1_data;
    logic [XLEN-1:0] byp2_data;
    logic            wb_hit1;
    logic            wb_hit2;

    // A write landing in the same cycle as the read address is missed by the
    // read-before-write RF, so it is captured here for one cycle.
    assign wb_hit1 = wb_we_i & (wb_dst_i != 5'd0) & (wb_dst_i == rf_src1_o);
    assign wb_hit2 = wb_we_i & (wb_dst_i != 5'd0) & (wb_dst_i == rf_src2_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            byp1_valid <= 1'b0;
            byp2_valid <= 1'b0;
            byp1_data  <= '0;
            byp2_data  <= '0;
        end else begin
            byp1_valid <= wb_hit1;
            byp2_valid <= wb_hit2;
            if (wb_hit1) byp1_data <= wb_data_i;
            if (wb_hit2) byp2_data <= wb_data_i;
        end
    end

    always_comb begin
        id_op1_o = byp1_valid ? byp1_data : rf_src1_q_i;
        id_op2_o = byp2_valid ? byp2_data : rf_src2_q_i;
        if (id_src1_o == 5'd0) id_op1_o = '0;
        if (id_src2_o == 5'd0) id_op2_o = '0;
    end
`else
    logic unused_wb;

    assign unused_wb = ^{wb_we_i, wb_dst_i, wb_data_i};

    always_comb begin
        id_op1_o = rf_src1_q_i;
        id_op2_o = rf_src2_q_i;
        if (id_src1_o == 5'd0) id_op1_o = '0;
        if (id_src2_o == 5'd0) id_op2_o = '0;
    end
`endif

endmodule

// File: tb/tb_rf_operand_fetch.sv
// tb/tb_rf_operand_fetch.sv - directed vector bench for rf_operand_fetch with a register-file model.
module tb_rf_operand_fetch;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             pd_valid_i;
    logic             pd_ready_o;
    logic [4:0]       pd_src1_i, pd_src2_i;
    logic [4:0]       rf_src1_o, rf_src2_o;
    logic [XLEN-1:0]  rf_src1_q_i, rf_src2_q_i;
    logic             wb_we_i;
    logic [4:0]       wb_dst_i;
    logic [XLEN-1:0]  wb_data_i;
    logic             id_valid_o;
    logic             id_ready_i;
    logic [4:0]       id_src1_o, id_src2_o;
    logic [XLEN-1:0]  id_op1_o, id_op2_o;
    logic             flush_i;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_operand_fetch #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .pd_valid_i(pd_valid_i), .pd_ready_o(pd_ready_o),
        .pd_src1_i(pd_src1_i), .pd_src2_i(pd_src2_i),
        .rf_src1_o(rf_src1_o), .rf_src2_o(rf_src2_o),
        .rf_src1_q_i(rf_src1_q_i), .rf_src2_q_i(rf_src2_q_i),
        .wb_we_i(wb_we_i), .wb_dst_i(wb_dst_i), .wb_data_i(wb_data_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_src1_o(id_src1_o), .id_src2_o(id_src2_o),
        .id_op1_o(id_op1_o), .id_op2_o(id_op2_o),
        .flush_i(flush_i), .stall_cnt_o(stall_cnt_o)
    );

    // Register file model: synchronous read; write-through unless the DUT bypasses.
    logic [XLEN-1:0] regs [32];
`ifdef RF_WB_BYPASS_EN
    localparam bit WT = 1'b0;
`else
    localparam bit WT = 1'b1;
`endif
    always @(posedge clk) begin
        if (rf_src1_o == 5'd0) rf_src1_q_i <= '0;
        else if (WT && wb_we_i && wb_dst_i == rf_src1_o) rf_src1_q_i <= wb_data_i;
        else rf_src1_q_i <= regs[rf_src1_o];
        if (rf_src2_o == 5'd0) rf_src2_q_i <= '0;
        else if (WT && wb_we_i && wb_dst_i == rf_src2_o) rf_src2_q_i <= wb_data_i;
        else rf_src2_q_i <= regs[rf_src2_o];
        if (wb_we_i && wb_dst_i != 5'd0) regs[wb_dst_i] <= wb_data_i;
    end

    typedef struct {
        logic        pdv;
        logic [4:0]  s1, s2;
        logic        rdy, fl, we;
        logic [4:0]  dst;
        logic [31:0] wd;
        logic        e_pdr;
        logic [4:0]  e_rf1, e_rf2;
        logic        e_idv;
        logic [4:0]  e_is1, e_is2;
        logic [31:0] e_op1, e_op2;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pdv, input logic [4:0] s1, input logic [4:0] s2,
                         input logic rdy, input logic fl, input logic we,
                         input logic [4:0] dst, input logic [31:0] wd);
        pd_valid_i = pdv; pd_src1_i = s1; pd_src2_i = s2;
        id_ready_i = rdy; flush_i = fl;
        wb_we_i = we; wb_dst_i = dst; wb_data_i = wd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          pdv s1 s2 rdy fl we dst wd            | pdr rf1 rf2 | idv is1 is2 op1           op2           cnt
        vecs[0]  = '{1, 5, 0, 1, 0, 0, 0, 32'h0,          1, 5, 0,  1, 5, 0, 32'h1234,     32'h0,        0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 5, 0,  1, 5, 0, 32'h1234,     32'h0,        1};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 5, 0,  1, 5, 0, 32'h1234,     32'h0,        2};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 5, 0,  1, 5, 0, 32'h1234,     32'h0,        3};
        vecs[4]  = '{1, 7, 9, 1, 0, 1, 7, 32'hDEAD,       1, 7, 9,  1, 7, 9, 32'hDEAD,     32'h9999,     3};
        vecs[5]  = '{0, 0, 0, 0, 0, 1, 9, 32'hBEEF,       0, 7, 9,  1, 7, 9, 32'hDEAD,     32'hBEEF,     4};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 7, 9,  1, 7, 9, 32'hDEAD,     32'hBEEF,     5};
        vecs[7]  = '{1, 3, 3, 1, 1, 0, 0, 32'h0,          1, 7, 9,  0, 7, 9, 32'hDEAD,     32'hBEEF,     5};
        vecs[8]  = '{0, 0, 0, 1, 0, 0, 0, 32'h0,          1, 7, 9,  0, 7, 9, 32'hDEAD,     32'hBEEF,     5};
        vecs[9]  = '{1, 0, 9, 0, 0, 0, 0, 32'h0,          1, 0, 9,  1, 0, 9, 32'h0,        32'hBEEF,     5};
        vecs[10] = '{0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF,   0, 0, 9,  1, 0, 9, 32'h0,        32'hBEEF,     6};
        vecs[11] = '{0, 0, 0, 0, 1, 0, 0, 32'h0,          0, 0, 9,  0, 0, 9, 32'h0,        32'hBEEF,     6};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 1, 5, 32'h1234);  tick;
        drive(0, 0, 0, 0, 0, 1, 7, 32'h7777);  tick;
        drive(0, 0, 0, 0, 0, 1, 9, 32'h9999);  tick;
        drive(0, 0, 0, 0, 0, 1, 3, 32'h3333);  tick;
        drive(1, 3, 3, 1, 0, 0, 0, 0);
        tick;
        chk("rst_id_valid", {31'b0, id_valid_o}, 32'd0);
        chk("rst_id_src1", {27'b0, id_src1_o}, 32'd0);
        chk("rst_id_src2", {27'b0, id_src2_o}, 32'd0);
        chk("rst_op1", id_op1_o, 32'd0);
        chk("rst_op2", id_op2_o, 32'd0);
        chk("rst_stall_cnt", {28'b0, stall_cnt_o}, 32'd0);

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("post_rst_pd_ready", {31'b0, pd_ready_o}, 32'd1);
        tick;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].pdv, vecs[i].s1, vecs[i].s2, vecs[i].rdy, vecs[i].fl,
                  vecs[i].we, vecs[i].dst, vecs[i].wd);
            #3;
            chk($sformatf("v%0d_pd_ready", i), {31'b0, pd_ready_o}, {31'b0, vecs[i].e_pdr});
            chk($sformatf("v%0d_rf_src1", i), {27'b0, rf_src1_o}, {27'b0, vecs[i].e_rf1});
            chk($sformatf("v%0d_rf_src2", i), {27'b0, rf_src2_o}, {27'b0, vecs[i].e_rf2});
            tick;
            chk($sformatf("v%0d_id_valid", i), {31'b0, id_valid_o}, {31'b0, vecs[i].e_idv});
            chk($sformatf("v%0d_id_src1", i), {27'b0, id_src1_o}, {27'b0, vecs[i].e_is1});
            chk($sformatf("v%0d_id_src2", i), {27'b0, id_src2_o}, {27'b0, vecs[i].e_is2});
            chk($sformatf("v%0d_op1", i), id_op1_o, vecs[i].e_op1);
            chk($sformatf("v%0d_op2", i), id_op2_o, vecs[i].e_op2);
            chk($sformatf("v%0d_stall_cnt", i), {28'b0, stall_cnt_o}, {28'b0, vecs[i].e_cnt});
        end

        // Long stall on x0 with writes to x0: counter saturates at 15, operand stays 0.
        drive(1, 0, 3, 0, 0, 0, 0, 0);
        tick;
        chk("sat_accept_valid", {31'b0, id_valid_o}, 32'd1);
        chk("sat_accept_op2", id_op2_o, 32'h3333);
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
            tick;
            chk($sformatf("sat_op1_c%0d", i), id_op1_o, 32'd0);
            chk($sformatf("sat_cnt_c%0d", i), {28'b0, stall_cnt_o}, (i + 7 > 15) ? 32'd15 : 32'(i + 7));
        end

        // Reset arriving mid-stall together with an accept attempt drops everything.
        drive(1, 5, 7, 1, 0, 0, 0, 0);
        rst = 1'b1;
        tick;
        chk("rst_mid_valid", {31'b0, id_valid_o}, 32'd0);
        chk("rst_mid_src1", {27'b0, id_src1_o}, 32'd0);
        chk("rst_mid_cnt", {28'b0, stall_cnt_o}, 32'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_mid_pd_ready", {31'b0, pd_ready_o}, 32'd1);
        tick;
        chk("rst_mid_idle_valid", {31'b0, id_valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_operand_fetch.md
RF_OPERAND_FETCH -- requirements
Module: rf_operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width.
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports pd_valid_i  in  1 and pd_ready_o  out  1  predecode-side handshake.
REQ-006 SHALL have ports pd_src1_i, pd_src2_i  in  5 each  source register indices from predecode.
REQ-007 SHALL have ports rf_src1_o, rf_src2_o  out  5 each  register-file read addresses (RF is synchronous-read: data one cycle after address).
REQ-008 SHALL have ports rf_src1_q_i, rf_src2_q_i  in  XLEN each  register-file read data.
REQ-009 SHALL have ports wb_we_i  in  1, wb_dst_i  in  5, wb_data_i  in  XLEN  writeback port (same signals drive the RF write port).
REQ-010 SHALL have ports id_valid_o  out  1 and id_ready_i  in  1  decode-side handshake.
REQ-011 SHALL have ports id_src1_o, id_src2_o  out  5 each  held source indices.
REQ-012 SHALL have ports id_op1_o, id_op2_o  out  XLEN each  resolved operands.
REQ-013 SHALL have port flush_i  in  1  discards the held entry.
REQ-014 SHALL have port stall_cnt_o  out  CNT_W  count of cycles with id_valid_o=1 and id_ready_i=0.

Function
REQ-015 SHALL implement a 2-state FSM: EMPTY (id_valid_o=0) and FULL (id_valid_o=1).
REQ-016 SHALL drive pd_ready_o = (state==EMPTY) | id_ready_i, combinationally.
REQ-017 SHALL accept when pd_valid_i & pd_ready_o & ~flush_i: capture pd_src1_i/pd_src2_i into id_src*_o, enter FULL next cycle.
REQ-018 SHALL, in FULL with id_ready_i=1 and no accept, return to EMPTY next cycle.
REQ-019 SHALL drive rf_src*_o = pd_src*_i when accepting, else id_src*_o (hold address during stall so RF data is re-read every cycle).
REQ-020 SHALL have accept-to-id_valid_o latency of exactly 1 cycle; back-to-back accepts sustain 1 entry/cycle.
REQ-021 SHALL force id_op*_o = 0 whenever the corresponding id_src*_o == 0, regardless of RF data or bypass.
REQ-022 SHALL otherwise drive id_op*_o from rf_src*_q_i, subject to REQ-030.
REQ-023 SHALL, on flush_i=1, enter EMPTY next cycle and block any accept in that cycle; flush has priority over accept and over id_ready_i.
REQ-024 SHALL increment stall_cnt_o each cycle with FULL & ~id_ready_i & ~flush_i, saturating at all-ones (no wrap).
REQ-025 SHALL keep id_src*_o and id_op*_o stable while FULL & ~id_ready_i, except operand updates caused by writeback to the held index.
REQ-026 SHALL ignore wb_we_i when wb_dst_i == 0.

Reset
REQ-027 SHALL, while rst=1, set state EMPTY, id_valid_o=0, id_src*_o=0, stall_cnt_o=0, bypass flags cleared; id_op*_o therefore read 0.
REQ-028 SHALL treat rst asserted mid-stall or coincident with an accept as dominant; the entry is dropped.
REQ-029 SHALL drive pd_ready_o=1 in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, with RF_WB_BYPASS_EN defined, keep per-source bypass registers: at each posedge, if wb_we_i & wb_dst_i!=0 & wb_dst_i==rf_src*_o, set byp_valid and capture wb_data_i, else clear byp_valid; id_op*_o = byp data when byp_valid, else rf_src*_q_i.
REQ-031 SHALL, without RF_WB_BYPASS_EN, contain no bypass registers and drive id_op*_o = rf_src*_q_i (x0 forced 0), requiring RF write-through.

Verification
REQ-032 Reset then accept src1=5,src2=0 with RF x5=0x1234 -> next cycle id_valid_o=1, id_op1_o=0x1234, id_op2_o=0.
REQ-033 FULL with id_ready_i=0 for 3 cycles -> pd_ready_o=0, rf_src*_o held, stall_cnt_o=3, operands unchanged.
REQ-034 (BYPASS_EN) accept src1=7 while wb writes x7=0xDEAD same cycle -> id_op1_o=0xDEAD next cycle, not old value.
REQ-035 During stall on src2=9, wb writes x9=0xBEEF -> id_op2_o=0xBEEF from following cycle onward.
REQ-036 flush_i=1 coincident with pd_valid_i=1 and FULL -> EMPTY next cycle, new entry not captured.
REQ-037 wb_we_i=1, wb_dst_i=0, data 0xFFFF_FFFF while src1=0 held -> id_op1_o stays 0; stall_cnt_o preset to max stays saturated.
